hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Drives the IF/ID register's LOADDEPEN stall and flush, the ID/EX bubble and hold, and the ID-stage operand forwarding selects.
- Sequences the multi-cycle divider occupying EX through a small FSM.
- Keeps saturating stall and flush performance counters.

---
 rtl/mips_ctrl_pkg.sv | 15 +
 rtl/fwd_sel.sv | 35 +++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS pipeline: forwarding select codes
// and the hazard controller's divide-sequencing FSM states.
package mips_ctrl_pkg;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_DIV_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding comparator: picks where one ID-stage source operand
// comes from, giving the younger EX producer priority over MEM.
module fwd_sel
  import mips_ctrl_pkg::*;
(
  input  logic [4:0] i_reg,
  input  logic       i_use,
  input  logic       i_exWreg,
  input  logic       i_exM2reg,
  input  logic [4:0] i_exRd,
  input  logic       i_memWreg,
  input  logic       i_memM2reg,
  input  logic [4:0] i_memRd,
  output logic [1:0] o_sel
);

  logic w_exHit;
  logic w_memHit;

  assign w_exHit  = i_exWreg  && (i_exRd  != 5'd0) && (i_exRd  == i_reg);
  assign w_memHit = i_memWreg && (i_memRd != 5'd0) && (i_memRd == i_reg);

  // A load still in EX has no data yet; the load-use stall covers that case.
  always_comb begin
    o_sel = FWD_RF;
    if (i_use) begin
      if (w_exHit && !i_exM2reg) begin
        o_sel = FWD_EXALU;
      end else if (w_memHit) begin
        o_sel = i_memM2reg ? FWD_MEMLD : FWD_MEMALU;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS core: load-use stall,
// branch flush, operand forwarding, multi-cycle divide hold and perf counters.
module hazard_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             branch_taken,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_div,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rd,
  output logic             LOADDEPEN,
  output logic             id_bubble,
  output logic             ex_hold,
  output logic             flush_if,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] DIV_RELOAD = 8'(DIV_LAT - 2);

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_divCnt;
  logic [7:0]       w_nextDivCnt;
  logic             w_exHold;
  logic             w_loadUse;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_RUN;
      r_divCnt <= 8'd0;
    end else begin
      r_state  <= w_nextState;
      r_divCnt <= w_nextDivCnt;
    end
  end

  // The first divide cycle holds from RUN, so DIV_WAIT only needs DIV_LAT-2
  // further hold cycles before the release cycle.
  always_comb begin
    w_nextState  = r_state;
    w_nextDivCnt = r_divCnt;
    w_exHold     = 1'b0;
    div_done     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (ex_is_div) begin
          w_exHold     = 1'b1;
          w_nextState  = ST_DIV_WAIT;
          w_nextDivCnt = DIV_RELOAD;
        end
      end
      ST_DIV_WAIT: begin
        if (r_divCnt != 8'd0) begin
          w_exHold     = 1'b1;
          w_nextDivCnt = r_divCnt - 8'd1;
        end else begin
          div_done    = 1'b1;
          w_nextState = ST_RUN;
        end
      end
      default: begin
        w_nextState = ST_RUN;
      end
    endcase
  end

  assign w_loadUse = ex_wreg && ex_m2reg && (ex_rd != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_rd)) ||
                      (id_use_rt && (id_rt == ex_rd)));

  // A divide hold outranks the load-use stall, which outranks a branch flush.
  always_comb begin
    ex_hold   = w_exHold;
    LOADDEPEN = w_exHold || w_loadUse;
    id_bubble = !w_exHold && w_loadUse;
    flush_if  = !w_exHold && !w_loadUse && branch_taken;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (LOADDEPEN && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
      if (flush_if && (r_flushCnt != '1)) begin
        r_flushCnt <= r_flushCnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;

  fwd_sel u_fwdRs (
    .i_reg      (id_rs),
    .i_use      (id_use_rs),
    .i_exWreg   (ex_wreg),
    .i_exM2reg  (ex_m2reg),
    .i_exRd     (ex_rd),
    .i_memWreg  (mem_wreg),
    .i_memM2reg (mem_m2reg),
    .i_memRd    (mem_rd),
    .o_sel      (fwda)
  );

  fwd_sel u_fwdRt (
    .i_reg      (id_rt),
    .i_use      (id_use_rt),
    .i_exWreg   (ex_wreg),
    .i_exM2reg  (ex_m2reg),
    .i_exRd     (ex_rd),
    .i_memWreg  (mem_wreg),
    .i_memM2reg (mem_m2reg),
    .i_memRd    (mem_rd),
    .o_sel      (fwdb)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; counters are narrowed to 4 bits so
// saturation is reachable in a handful of cycles.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             resetn;
  logic [4:0]       id_rs, id_rt, ex_rd, mem_rd;
  logic             id_use_rs, id_use_rt, branch_taken;
  logic             ex_wreg, ex_m2reg, ex_is_div, mem_wreg, mem_m2reg;
  logic             LOADDEPEN, id_bubble, ex_hold, flush_if, div_done;
  logic [1:0]       fwda, fwdb;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.DIV_LAT(8), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .branch_taken (branch_taken),
    .ex_wreg      (ex_wreg),
    .ex_m2reg     (ex_m2reg),
    .ex_rd        (ex_rd),
    .ex_is_div    (ex_is_div),
    .mem_wreg     (mem_wreg),
    .mem_m2reg    (mem_m2reg),
    .mem_rd       (mem_rd),
    .LOADDEPEN    (LOADDEPEN),
    .id_bubble    (id_bubble),
    .ex_hold      (ex_hold),
    .flush_if     (flush_if),
    .fwda         (fwda),
    .fwdb         (fwdb),
    .div_done     (div_done),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(
    input logic [4:0] rs, input logic [4:0] rt, input logic useRs, input logic useRt,
    input logic exW, input logic exLd, input logic [4:0] exRd,
    input logic memW, input logic memLd, input logic [4:0] memRd,
    input logic br, input logic div);
    @(negedge clock);
    id_rs = rs; id_rt = rt; id_use_rs = useRs; id_use_rt = useRt;
    ex_wreg = exW; ex_m2reg = exLd; ex_rd = exRd;
    mem_wreg = memW; mem_m2reg = memLd; mem_rd = memRd;
    branch_taken = br; ex_is_div = div;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn = 1'b0;
    id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; branch_taken = 0;
    ex_wreg = 0; ex_m2reg = 0; ex_rd = '0; ex_is_div = 0;
    mem_wreg = 0; mem_m2reg = 0; mem_rd = '0;
    @(negedge clock); #1;
    checkOutput("rst_LOADDEPEN", 32'(LOADDEPEN), 32'd0);
    checkOutput("rst_id_bubble", 32'(id_bubble), 32'd0);
    checkOutput("rst_ex_hold",   32'(ex_hold),   32'd0);
    checkOutput("rst_flush_if",  32'(flush_if),  32'd0);
    checkOutput("rst_fwda",      32'(fwda),      32'd0);
    checkOutput("rst_fwdb",      32'(fwdb),      32'd0);
    checkOutput("rst_div_done",  32'(div_done),  32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    resetn = 1'b1;

    // Load-use on rs with a taken branch: stall wins, no flush.
    applyStimulus(8, 0, 1, 0, 1, 1, 8, 0, 0, 0, 1, 0);
    checkOutput("lu_LOADDEPEN", 32'(LOADDEPEN), 32'd1);
    checkOutput("lu_id_bubble", 32'(id_bubble), 32'd1);
    checkOutput("lu_flush_if",  32'(flush_if),  32'd0);
    checkOutput("lu_ex_hold",   32'(ex_hold),   32'd0);
    checkOutput("lu_fwda",      32'(fwda),      32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("br_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("br_LOADDEPEN", 32'(LOADDEPEN), 32'd0);
    checkOutput("br_flush_if",  32'(flush_if),  32'd1);
    checkOutput("br_flush_cnt0", 32'(flush_cnt), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("br_flush_cnt1", 32'(flush_cnt), 32'd1);
    checkOutput("br_flush_off", 32'(flush_if), 32'd0);

    // Register 0 and unused operands never stall.
    applyStimulus(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_LOADDEPEN", 32'(LOADDEPEN), 32'd0);
    checkOutput("r0_fwda",      32'(fwda),      32'd0);
    applyStimulus(8, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0);
    checkOutput("nouse_LOADDEPEN", 32'(LOADDEPEN), 32'd0);
    checkOutput("nouse_id_bubble", 32'(id_bubble), 32'd0);
    checkOutput("nouse_fwda",      32'(fwda),      32'd0);
    applyStimulus(0, 8, 0, 1, 1, 1, 8, 0, 0, 0, 0, 0);
    checkOutput("lurt_LOADDEPEN", 32'(LOADDEPEN), 32'd1);
    checkOutput("lurt_stall_cnt", 32'(stall_cnt), 32'd1);

    // Forwarding selects.
    applyStimulus(5, 0, 1, 0, 1, 0, 5, 0, 0, 0, 0, 0);
    checkOutput("fw_exalu_fwda", 32'(fwda), 32'd1);
    checkOutput("fw_exalu_stall", 32'(stall_cnt), 32'd2);
    checkOutput("fw_exalu_LOADDEPEN", 32'(LOADDEPEN), 32'd0);
    applyStimulus(0, 6, 0, 1, 0, 0, 0, 1, 1, 6, 0, 0);
    checkOutput("fw_memld_fwdb", 32'(fwdb), 32'd3);
    checkOutput("fw_memld_fwda", 32'(fwda), 32'd0);
    applyStimulus(5, 5, 1, 0, 1, 0, 5, 1, 0, 5, 0, 0);
    checkOutput("fw_prio_fwda",  32'(fwda), 32'd1);
    checkOutput("fw_nouse_fwdb", 32'(fwdb), 32'd0);
    applyStimulus(7, 7, 1, 1, 0, 0, 0, 1, 0, 7, 0, 0);
    checkOutput("fw_memalu_fwda", 32'(fwda), 32'd2);
    checkOutput("fw_memalu_fwdb", 32'(fwdb), 32'd2);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("fw_r0_fwda", 32'(fwda), 32'd0);
    checkOutput("fw_r0_fwdb", 32'(fwdb), 32'd0);

    // Divide, DIV_LAT=8: hold for 7 cycles, done on the 8th; branch in cycle 3.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k == 3), 1);
      checkOutput($sformatf("div_hold_c%0d", k), 32'(ex_hold),  32'(k < 8));
      checkOutput($sformatf("div_done_c%0d", k), 32'(div_done), 32'(k == 8));
      checkOutput($sformatf("div_ldep_c%0d", k), 32'(LOADDEPEN), 32'(k < 8));
      if (k == 3) begin
        checkOutput("div_flush_if", 32'(flush_if), 32'd0);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("div_after_hold", 32'(ex_hold),   32'd0);
    checkOutput("div_after_done", 32'(div_done),  32'd0);
    checkOutput("div_stall_cnt",  32'(stall_cnt), 32'd9);
    checkOutput("div_flush_cnt",  32'(flush_cnt), 32'd1);

    // Stall counter saturates at all-ones.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8, 0, 1, 0, 1, 1, 8, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    applyStimulus(8, 0, 1, 0, 1, 1, 8, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_stall_hold", 32'(stall_cnt), 32'd15);

    // Reset asserted in cycle 3 of a divide.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("rdiv_hold_before", 32'(ex_hold), 32'd1);
    #1;
    resetn = 1'b0;
    ex_is_div = 1'b0;
    #1;
    checkOutput("rdiv_hold_async", 32'(ex_hold),   32'd0);
    checkOutput("rdiv_stall_cnt",  32'(stall_cnt), 32'd0);
    checkOutput("rdiv_flush_cnt",  32'(flush_cnt), 32'd0);
    @(negedge clock); #1;
    resetn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("rdiv_run_hold_c%0d", k), 32'(ex_hold),  32'd0);
      checkOutput($sformatf("rdiv_run_done_c%0d", k), 32'(div_done), 32'd0);
    end
    checkOutput("rdiv_stall_after", 32'(stall_cnt), 32'd0);
    checkOutput("rdiv_flush_after", 32'(flush_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
